// File: rtl/eq_cmp_pkg.sv
// Shared types and helpers for the eq_cmp_sched comparator scheduler.
package eq_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic OP_EQ = 1'b0;
    localparam logic OP_NE = 1'b1;

    // Width of an index into n items; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/eq_cmp_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter
    import eq_cmp_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_id,
    output logic            gnt_valid
);

    int idx;

    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_id    = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/eq_cmp_sched.sv
// Shares one CHUNK-bit equality slice between NREQ requesters, scanning LSB
// chunks first and stopping at the first mismatch; results return tagged by id.
module eq_cmp_sched
    import eq_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int NREQ  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                    rsp_result,
    output logic                    busy,
    output state_e                  dbg_state
);

    // Handshakes: a transfer happens on the rising edge where valid && ready
    // are both high; ready never depends on the same port's valid being
    // withdrawn, and a responder holds its payload until the transfer.

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = id_width(NREQ);
    localparam int CW  = id_width(NCH);

    if ((WIDTH % CHUNK) != 0 || NREQ < 2) begin : g_bad_param
        $error("eq_cmp_sched: WIDTH must be a multiple of CHUNK and NREQ >= 2");
    end

    state_e           state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             eq_acc_q, eq_acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             op_q, op_d;
    logic [IW-1:0]    id_q, id_d;
    logic             result_q, result_d;

    logic [NREQ-1:0]  gnt;
    logic [IW-1:0]    gnt_id;
    logic             gnt_valid;

    logic [WIDTH-1:0] req_a_arr [NREQ];
    logic [WIDTH-1:0] req_b_arr [NREQ];
    logic [CHUNK-1:0] a_ch [NCH];
    logic [CHUNK-1:0] b_ch [NCH];
    logic             eq_next;

    for (genvar i = 0; i < NREQ; i++) begin : g_req_unpack
        assign req_a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign req_b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chunk
        assign a_ch[k] = a_q[k*CHUNK +: CHUNK];
        assign b_ch[k] = b_q[k*CHUNK +: CHUNK];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    assign eq_next = eq_acc_q & (a_ch[cnt_q] == b_ch[cnt_q]);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        eq_acc_d  = eq_acc_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        id_d      = id_q;
        result_d  = result_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                // Ready is suppressed during reset so no requester sees a
                // phantom acceptance while the block is held.
                req_ready = reset ? '0 : gnt;
                if (gnt_valid) begin
                    a_d      = req_a_arr[gnt_id];
                    b_d      = req_b_arr[gnt_id];
                    op_d     = req_op[gnt_id];
                    id_d     = gnt_id;
                    cnt_d    = '0;
                    eq_acc_d = 1'b1;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                eq_acc_d = eq_next;
                if (!eq_next || cnt_q == CW'(NCH - 1)) begin
                    result_d = (op_q == OP_NE) ? ~eq_next : eq_next;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            eq_acc_q <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_EQ;
            id_q     <= '0;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            eq_acc_q <= eq_acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            id_q     <= id_d;
            result_q <= result_d;
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_eq_cmp_sched.sv
// Self-checking bench for eq_cmp_sched with WIDTH=16, CHUNK=4, NREQ=2.
module tb_eq_cmp_sched;
    import eq_cmp_pkg::*;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NREQ  = 2;
    localparam int NCH   = WIDTH / CHUNK;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*WIDTH-1:0]   req_a;
    logic [NREQ*WIDTH-1:0]   req_b;
    logic [NREQ-1:0]         req_op;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [$clog2(NREQ)-1:0] rsp_id;
    logic                    rsp_result;
    logic                    busy;
    state_e                  dbg_state;

    int n_checks  = 0;
    int n_pass    = 0;
    int rsp_count = 0;
    int model_ptr = 0;
    bit mon_en    = 1'b0;

    typedef struct {
        logic [1:0]  vmask;
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        int          exp_id;
        int          exp_res;
        int          exp_lat;
        string       name;
    } vec_t;

    vec_t tbl[6];

    eq_cmp_sched #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK),
        .NREQ  (NREQ)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Scoreboard helpers
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(posedge clk) begin
        if (!reset && rsp_valid && rsp_ready) rsp_count++;
    end

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            check("ready_onehot0", int'($onehot0(req_ready)), 1);
            check("ready_only_idle", int'((req_ready != 0) && (busy || reset)), 0);
        end
    end

    // Reference model: works on whole operands, not on the chunk counter.
    function automatic int first_mismatch(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        x = a ^ b;
        for (int k = 0; k < NCH; k++) begin
            if (((x >> (CHUNK * k)) & 16'hF) != 0) return k;
        end
        return -1;
    endfunction

    function automatic int model_lat(input logic [15:0] a, input logic [15:0] b);
        int fm;
        fm = first_mismatch(a, b);
        return (fm < 0) ? NCH + 1 : fm + 2;
    endfunction

    function automatic int model_res(input logic [15:0] a, input logic [15:0] b, input logic op);
        return op ? int'(a != b) : int'(a == b);
    endfunction

    function automatic int model_grant(input logic [1:0] vmask, input int ptr);
        for (int off = 0; off < NREQ; off++) begin
            if (vmask[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
        end
        return -1;
    endfunction

    // Driver: one full transaction with rsp_ready held high.
    // Latency is counted so that the acceptance edge is cycle 0 and rsp_valid
    // observed after edge T+c counts as first high at cycle T+c+1.
    task automatic run_txn(input logic [1:0] vmask, input logic [15:0] a,
                           input logic [15:0] b, input logic op, input bit keep,
                           input int exp_id, input int exp_res, input int exp_lat,
                           input string name);
        int waited;
        int lat;
        @(negedge clk);
        req_valid = vmask;
        req_a     = {a, a};
        req_b     = {b, b};
        req_op    = {op, op};
        rsp_ready = 1'b1;
        #1;
        waited = 0;
        while (req_ready == 0 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check({name, "/ready"}, int'(req_ready), 1 << exp_id);
        @(posedge clk);
        #1;
        if (!keep) begin
            req_valid = '0;
            req_a     = ~req_a;
            req_b     = req_b ^ 32'h5A5A_0F0F;
            req_op    = ~req_op;
        end
        lat = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = c + 1;
                break;
            end
        end
        check({name, "/latency"}, lat, exp_lat);
        check({name, "/rsp_id"}, int'(rsp_id), exp_id);
        check({name, "/rsp_result"}, int'(rsp_result), exp_res);
        @(posedge clk);
        #1;
        model_ptr = (exp_id + 1) % NREQ;
    endtask

    initial begin
        int cnt0;
        int waited;
        logic [1:0]  vm;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rop;
        int          eid;

        tbl[0] = '{2'b01, 16'hA5A5, 16'hA5A5, OP_EQ, 0, 1, 5, "eq_full_match"};
        tbl[1] = '{2'b10, 16'h00F3, 16'h00F0, OP_NE, 1, 1, 2, "ne_mismatch_c0"};
        tbl[2] = '{2'b01, 16'h1234, 16'h9234, OP_EQ, 0, 0, 5, "eq_mismatch_c3"};
        tbl[3] = '{2'b01, 16'h1234, 16'h9234, OP_NE, 0, 1, 5, "ne_mismatch_c3"};
        tbl[4] = '{2'b01, 16'h0100, 16'h0000, OP_EQ, 0, 0, 4, "eq_mismatch_c2"};
        tbl[5] = '{2'b10, 16'h0010, 16'h0000, OP_NE, 1, 1, 3, "ne_mismatch_c1"};

        // Reset state, with both requesters asking so req_ready=0 is meaningful
        reset     = 1'b1;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset/rsp_valid", int'(rsp_valid), 0);
        check("reset/rsp_id", int'(rsp_id), 0);
        check("reset/rsp_result", int'(rsp_result), 0);
        check("reset/busy", int'(busy), 0);
        check("reset/req_ready", int'(req_ready), 0);
        mon_en = 1'b1;
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        model_ptr = 0;

        // Table-driven directed vectors
        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i].vmask, tbl[i].a, tbl[i].b, tbl[i].op, 1'b0,
                    tbl[i].exp_id, tbl[i].exp_res, tbl[i].exp_lat, tbl[i].name);
        end

        // Fairness: both continuously valid, identical operands
        for (int i = 0; i < 4; i++) begin
            eid = model_grant(2'b11, model_ptr);
            check("fair/expected_order", eid, i % 2);
            run_txn(2'b11, 16'h3C3C, 16'h3C3C, OP_EQ, 1'b1, eid, 1, 5, "fair");
        end
        req_valid = '0;

        // Back-pressure: hold rsp_ready low for 10 cycles in RESP
        @(negedge clk);
        req_valid = 2'b01;
        req_a     = {16'h1234, 16'h1234};
        req_b     = {16'h9234, 16'h9234};
        req_op    = 2'b00;
        rsp_ready = 1'b0;
        #1;
        check("hold/ready", int'(req_ready), 2'b01);
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        waited = 0;
        while (!rsp_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("hold/rsp_valid_seen", int'(rsp_valid), 1);
        cnt0 = rsp_count;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("hold/rsp_valid", int'(rsp_valid), 1);
            check("hold/rsp_id", int'(rsp_id), 0);
            check("hold/rsp_result", int'(rsp_result), 0);
            check("hold/busy", int'(busy), 1);
            check("hold/req_ready", int'(req_ready), 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        model_ptr = 1;
        repeat (3) @(negedge clk);
        check("hold/one_response", rsp_count - cnt0, 1);
        check("hold/busy_after", int'(busy), 0);

        // Reset two cycles into SCAN aborts the transaction
        @(negedge clk);
        req_valid = 2'b01;
        req_a     = {16'hA5A5, 16'hA5A5};
        req_b     = {16'hA5A5, 16'hA5A5};
        req_op    = 2'b00;
        #1;
        check("abort/ready", int'(req_ready), 2'b01);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        cnt0 = rsp_count;
        req_valid = 2'b11;
        reset     = 1'b1;
        #1;
        check("abort/rsp_valid", int'(rsp_valid), 0);
        check("abort/busy", int'(busy), 0);
        check("abort/req_ready", int'(req_ready), 0);
        check("abort/state_idle", int'(dbg_state), int'(IDLE));
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        model_ptr = 0;
        repeat (2) @(negedge clk);
        check("abort/no_response", rsp_count - cnt0, 0);
        run_txn(2'b11, 16'h0F0F, 16'h0F0F, OP_EQ, 1'b0,
                model_grant(2'b11, model_ptr), 1, 5, "after_abort");

        // Randomized stimulus against the reference model
        for (int i = 0; i < 40; i++) begin
            vm  = 2'($urandom_range(1, 3));
            ra  = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (16'h1 << $urandom_range(0, 15));
                2:       rb = ra ^ (16'hF << (CHUNK * $urandom_range(0, NCH - 1)));
                default: rb = 16'($urandom);
            endcase
            rop = 1'($urandom_range(0, 1));
            eid = model_grant(vm, model_ptr);
            run_txn(vm, ra, rb, rop, 1'b0, eid, model_res(ra, rb, rop),
                    model_lat(ra, rb), "random");
        end

        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
